// File: rtl/bridge_pkg.sv
// Shared definitions for the bridge RAM arbiter: default widths, port ids and the pipeline tag.
package bridge_pkg;

  localparam int ADDR_W_DEF       = 8;
  localparam int DATA_W_DEF       = 8;
  localparam int STARVE_LIMIT_DEF = 4;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
    logic we;
  } tag_t;

endpackage

// File: rtl/bridge_prio_arb.sv
// Fixed-priority grant to port A, with a starvation guard and a lock that favour port B.
module bridge_prio_arb
  import bridge_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic a_req,
  input  logic b_req,
  input  logic b_lock,
  output logic a_gnt,
  output logic b_gnt
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             lock_held;
  logic             b_force;

  // While the lock is held and B is silent, nobody is granted.
  always_comb begin
    a_gnt   = 1'b0;
    b_gnt   = 1'b0;
    b_force = b_req && ((starve_cnt == LIMIT) || lock_held);
    if (!rst) begin
      if (b_force) begin
        b_gnt = 1'b1;
      end else if (!lock_held) begin
        if (a_req) begin
          a_gnt = 1'b1;
        end else if (b_req) begin
          b_gnt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      lock_held  <= 1'b0;
    end else begin
      if (!b_req || b_gnt) begin
        starve_cnt <= '0;
      end else if (a_gnt && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      if (!b_lock) begin
        lock_held <= 1'b0;
      end else if (b_gnt) begin
        lock_held <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/bridge_ram_arbiter.sv
// Shares the single-port bridge RAM between port A and port B with a fixed
// 3-cycle grant-to-done pipeline; completions come back in grant order.
module bridge_ram_arbiter
  import bridge_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_lock,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,

  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  tag_t tag_s1;
  logic s2_valid;
  logic s2_port;

  bridge_prio_arb #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .a_req  (a_req),
    .b_req  (b_req),
    .b_lock (b_lock),
    .a_gnt  (a_gnt),
    .b_gnt  (b_gnt)
  );

  // The S1 tag register doubles as the RAM enable/write strobes.
  assign ram_en = tag_s1.valid;
  assign ram_we = tag_s1.we;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_s1   <= '0;
      s2_valid <= 1'b0;
      s2_port  <= PORT_A;
      ram_addr <= '0;
      ram_din  <= '0;
      a_done   <= 1'b0;
      b_done   <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      tag_s1.valid <= a_gnt | b_gnt;
      tag_s1.port  <= b_gnt ? PORT_B : PORT_A;
      tag_s1.we    <= (a_gnt & a_we) | (b_gnt & b_we);

      if (a_gnt) begin
        ram_addr <= a_addr;
        ram_din  <= a_wdata;
      end else if (b_gnt) begin
        ram_addr <= b_addr;
        ram_din  <= b_wdata;
      end

      s2_valid <= tag_s1.valid;
      s2_port  <= tag_s1.port;

      a_done <= s2_valid && (s2_port == PORT_A);
      b_done <= s2_valid && (s2_port == PORT_B);

      // Writes also return the pre-write contents.
      if (s2_valid && (s2_port == PORT_A)) begin
        a_rdata <= ram_dout;
      end
      if (s2_valid && (s2_port == PORT_B)) begin
        b_rdata <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_bridge_ram_arbiter.sv
// Bench for bridge_ram_arbiter: table-driven grant vectors plus a scoreboard of returned data.
module tb_bridge_ram_arbiter;
  import bridge_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, a_done, b_gnt, b_done, ram_en, ram_we;
  logic [DW-1:0] a_rdata, b_rdata, ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic [AW-1:0] ram_addr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bridge_ram_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .a_done   (a_done),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_lock   (b_lock),
    .b_gnt    (b_gnt),
    .b_done   (b_done),
    .b_rdata  (b_rdata),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // Single-port RAM, read-before-write, registered output.
  logic [DW-1:0] mem [256] = '{default: 8'h00};
  always @(posedge clk) begin
    if (ram_en) begin
      ram_dout <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_din;
    end
  end

  typedef struct {
    logic       a_req, a_we;
    logic [7:0] a_addr, a_wdata;
    logic       b_req, b_we, b_lock;
    logic [7:0] b_addr, b_wdata;
    logic       exp_a, exp_b;
  } vec_t;

  typedef struct {
    logic       port;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  vec_t       vecs[$];
  exp_t       sb[$];
  logic [7:0] ref_mem [256] = '{default: 8'h00};

  function automatic vec_t mk(input logic ar, input logic aw, input logic [7:0] aa,
                              input logic [7:0] ad, input logic br, input logic bw,
                              input logic bl, input logic [7:0] ba, input logic [7:0] bd,
                              input logic ea, input logic eb);
    vec_t v;
    v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad;
    v.b_req = br; v.b_we = bw; v.b_lock = bl; v.b_addr = ba; v.b_wdata = bd;
    v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic port, input logic we, input logic [7:0] addr,
                      input logic [7:0] wdata);
    exp_t e;
    e.port = port;
    e.data = ref_mem[addr];
    e.cyc  = cyc;
    sb.push_back(e);
    if (we) ref_mem[addr] = wdata;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input vec_t v, input string name);
    a_req = v.a_req; a_we = v.a_we; a_addr = v.a_addr; a_wdata = v.a_wdata;
    b_req = v.b_req; b_we = v.b_we; b_lock = v.b_lock; b_addr = v.b_addr; b_wdata = v.b_wdata;
    #1;
    checks++;
    if (a_gnt !== v.exp_a || b_gnt !== v.exp_b) begin
      failures++;
      $display("FAIL %s cyc=%0d: gnt a=%b b=%b expected a=%b b=%b",
               name, cyc, a_gnt, b_gnt, v.exp_a, v.exp_b);
    end
    if (a_gnt === 1'b1) push(PORT_A, v.a_we, v.a_addr, v.a_wdata);
    else if (b_gnt === 1'b1) push(PORT_B, v.b_we, v.b_addr, v.b_wdata);
    @(posedge clk);
    #1;
  endtask

  // Completion monitor: port, data and 3-cycle latency against the scoreboard.
  exp_t mon_e;
  logic mon_port;
  logic [7:0] mon_data;
  always @(negedge clk) begin
    if (a_done === 1'b1 || b_done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL spurious_done cyc=%0d: a_done=%b b_done=%b expected none", cyc, a_done, b_done);
      end else begin
        mon_e = sb.pop_front();
        mon_port = b_done;
        mon_data = b_done ? b_rdata : a_rdata;
        if ((a_done && b_done) || mon_port !== mon_e.port || mon_data !== mon_e.data
            || cyc != mon_e.cyc + 3) begin
          failures++;
          $display("FAIL done cyc=%0d: port=%b data=%0h at cyc %0d expected port=%b data=%0h at cyc %0d",
                   cyc, mon_port, mon_data, cyc, mon_e.port, mon_e.data, mon_e.cyc + 3);
        end
      end
    end else if (sb.size() != 0 && cyc > sb[0].cyc + 3) begin
      checks++;
      failures++;
      $display("FAIL missing_done cyc=%0d: no done, expected port=%b data=%0h", cyc, sb[0].port, sb[0].data);
      mon_e = sb.pop_front();
    end
  end

  initial begin
    vec_t idle;
    idle = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Reset: gnt suppressed, outputs at reset values.
    repeat (2) @(posedge clk);
    #1;
    a_req = 1'b1; b_req = 1'b1;
    #1;
    chk("rst_a_gnt", 32'(a_gnt), 32'h0);
    chk("rst_b_gnt", 32'(b_gnt), 32'h0);
    chk("rst_ram_en", 32'(ram_en), 32'h0);
    chk("rst_done", 32'({a_done, b_done}), 32'h0);
    chk("rst_rdata", 32'({a_rdata, b_rdata}), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; a_req = 1'b0; b_req = 1'b0;

    // Write then read same address from A.
    vecs.push_back(mk(1'b1, 1'b1, 8'h10, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0));
    vecs.push_back(idle);
    vecs.push_back(idle);
    // Both held: AAAAB AAAAB.
    for (int i = 0; i < 10; i++) begin
      vecs.push_back(mk(1'b1, 1'b0, 8'h30 + 8'(i), 8'h00, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00,
                        (i % 5) != 4, (i % 5) == 4));
    end
    vecs.push_back(idle);
    // B locked burst; A blocked until the cycle after b_lock falls.
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h80, 8'h01, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 8'h81, 8'h00, 1'b1, 1'b1, 1'b1, 8'h81, 8'h02, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 8'h81, 8'h00, 1'b1, 1'b1, 1'b1, 8'h82, 8'h03, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 8'h81, 8'h00, 1'b1, 1'b1, 1'b1, 8'h83, 8'h04, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 8'h81, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0));
    vecs.push_back(idle);
    // Same-cycle A read / B write on 0xFF, then A reads the new value.
    vecs.push_back(mk(1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hC3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hC3, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // Drain, then 10 quiet cycles.
    repeat (4) step(idle, "drain");
    for (int i = 0; i < 10; i++) begin
      step(idle, "quiet");
      chk("quiet_ram_en", 32'(ram_en), 32'h0);
      chk("quiet_done", 32'({a_done, b_done}), 32'h0);
    end
    chk("quiet_starve_cnt", 32'(dut.u_arb.starve_cnt), 32'h0);

    // Reset one cycle after a B write grant.
    step(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h90, 8'hA7, 1'b0, 1'b1), "rst_bwrite");
    rst = 1'b1; a_req = 1'b1; a_addr = 8'h00; b_req = 1'b0; b_we = 1'b0;
    sb.delete();
    #1;
    chk("midrst_a_gnt", 32'(a_gnt), 32'h0);
    chk("midrst_inflight_en", 32'({ram_en, ram_we}), 32'h3);
    chk("midrst_inflight_addr", 32'(ram_addr), 32'h90);
    @(posedge clk);
    #1;
    rst = 1'b0; a_req = 1'b0;
    #1;
    chk("postrst_ram_en_we", 32'({ram_en, ram_we}), 32'h0);
    chk("postrst_ram_addr", 32'(ram_addr), 32'h0);
    chk("postrst_ram_din", 32'(ram_din), 32'h0);
    chk("postrst_done", 32'({a_done, b_done}), 32'h0);
    chk("postrst_rdata", 32'({a_rdata, b_rdata}), 32'h0);
    chk("postrst_mem90", 32'(mem[8'h90]), 32'hA7);
    @(posedge clk);
    #1;
    repeat (4) step(idle, "postrst_idle");
    step(mk(1'b1, 1'b0, 8'h90, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0), "postrst_aread");
    repeat (5) step(idle, "final_drain");
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
